// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the parametrised register file with scoreboard.
package regfile_pkg;

  localparam int NREGS_DEF = 32;
  localparam int WIDTH_DEF = 32;
  localparam int NRD_DEF   = 2;
  localparam int ZERO_ADDR = 0;

  function automatic int addr_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_scoreboard_wen_decoder.sv
// One-hot write-enable decoder; also drives the scoreboard clear terms.
module wen_decoder
  import regfile_pkg::*;
#(
  parameter int NREGS    = NREGS_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                     we,
  input  logic [addr_w(NREGS)-1:0] waddr,
  output logic [NREGS-1:0]         wen
);

  localparam int AW = addr_w(NREGS);

  always_comb begin
    wen = '0;
    for (int k = 0; k < NREGS; k++) begin
      if (we && (waddr == AW'(k))) wen[k] = 1'b1;
    end
    // A hardwired-zero register must never see a write or a busy clear.
    if (ZERO_REG != 0) wen[ZERO_ADDR] = 1'b0;
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with decoded write enables, write-first bypassed reads and a busy scoreboard.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS    = NREGS_DEF,
  parameter int WIDTH    = WIDTH_DEF,
  parameter int NRD      = NRD_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic [addr_w(NREGS)-1:0]     waddr,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         iss_valid,
  input  logic [addr_w(NREGS)-1:0]     iss_addr,
  input  logic [NRD*addr_w(NREGS)-1:0] ra,
  output logic [NRD*WIDTH-1:0]         rdata,
  output logic [NRD-1:0]               rbusy,
  output logic [NREGS-1:0]             busy_vec
);

  localparam int AW = addr_w(NREGS);

  logic [NREGS-1:0] wen;
  logic [NREGS-1:0] set_vec;
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [AW-1:0]    ra_i;

  wen_decoder #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG)
  ) u_wen_dec (
    .we    (we),
    .waddr (waddr),
    .wen   (wen)
  );

  always_comb begin
    set_vec = '0;
    if (iss_valid) set_vec[iss_addr] = 1'b1;
    if (ZERO_REG != 0) set_vec[ZERO_ADDR] = 1'b0;
  end

  // A new producer supersedes a retiring one, so set dominates clear.
  assign busy_d = set_vec | (busy_q & ~wen);

  always_comb begin
    for (int k = 0; k < NREGS; k++) begin
      regs_d[k] = wen[k] ? wdata : regs_q[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      regs_q <= '{default: '0};
    end else begin
      busy_q <= busy_d;
      regs_q <= regs_d;
    end
  end

  // Each port resolves independently; a same-cycle write is forwarded, never stalled.
  always_comb begin
    rdata = '0;
    rbusy = '0;
    ra_i  = '0;
    for (int i = 0; i < NRD; i++) begin
      ra_i = ra[i*AW +: AW];
      if ((ZERO_REG != 0) && (ra_i == AW'(ZERO_ADDR))) begin
        rdata[i*WIDTH +: WIDTH] = '0;
      end else if (wen[ra_i]) begin
        rdata[i*WIDTH +: WIDTH] = wdata;
      end else begin
        rdata[i*WIDTH +: WIDTH] = regs_q[ra_i];
      end
      rbusy[i] = busy_q[ra_i] & ~wen[ra_i];
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench: three configurations, directed scenarios plus randomized traffic vs a model.
module tb_regfile_scoreboard;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Config A: defaults (32 x 32, 2 ports, zero register)
  logic        a_we, a_iss;
  logic [4:0]  a_waddr, a_iss_addr;
  logic [31:0] a_wdata;
  logic [9:0]  a_ra;
  logic [63:0] a_rdata;
  logic [1:0]  a_rbusy;
  logic [31:0] a_busy;

  // Config B: register 0 ordinary
  logic        b_we, b_iss;
  logic [4:0]  b_waddr, b_iss_addr;
  logic [31:0] b_wdata;
  logic [9:0]  b_ra;
  logic [63:0] b_rdata;
  logic [1:0]  b_rbusy;
  logic [31:0] b_busy;

  // Config C: 8 x 16, 4 ports
  logic        c_we, c_iss;
  logic [2:0]  c_waddr, c_iss_addr;
  logic [15:0] c_wdata;
  logic [11:0] c_ra;
  logic [63:0] c_rdata;
  logic [3:0]  c_rbusy;
  logic [7:0]  c_busy;

  regfile_scoreboard u_a (
    .clk(clk), .rst(rst), .we(a_we), .waddr(a_waddr), .wdata(a_wdata),
    .iss_valid(a_iss), .iss_addr(a_iss_addr), .ra(a_ra),
    .rdata(a_rdata), .rbusy(a_rbusy), .busy_vec(a_busy)
  );

  regfile_scoreboard #(.ZERO_REG(0)) u_b (
    .clk(clk), .rst(rst), .we(b_we), .waddr(b_waddr), .wdata(b_wdata),
    .iss_valid(b_iss), .iss_addr(b_iss_addr), .ra(b_ra),
    .rdata(b_rdata), .rbusy(b_rbusy), .busy_vec(b_busy)
  );

  regfile_scoreboard #(.NREGS(8), .WIDTH(16), .NRD(4)) u_c (
    .clk(clk), .rst(rst), .we(c_we), .waddr(c_waddr), .wdata(c_wdata),
    .iss_valid(c_iss), .iss_addr(c_iss_addr), .ra(c_ra),
    .rdata(c_rdata), .rbusy(c_rbusy), .busy_vec(c_busy)
  );

  // Reference model of config A: architectural state only.
  logic [31:0] m_regs [32];
  logic [31:0] m_busy;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= '0;
      m_busy <= '0;
    end else begin
      if (a_we && a_waddr != 5'd0) begin
        m_regs[a_waddr] <= a_wdata;
        m_busy[a_waddr] <= 1'b0;
      end
      if (a_iss && a_iss_addr != 5'd0) m_busy[a_iss_addr] <= 1'b1;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (a_we && a_waddr == a) return a_wdata;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    if (a_we && a_waddr == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    a_we = 0; a_iss = 0; a_waddr = 0; a_iss_addr = 0; a_wdata = 0; a_ra = 0;
    b_we = 0; b_iss = 0; b_waddr = 0; b_iss_addr = 0; b_wdata = 0; b_ra = 0;
    c_we = 0; c_iss = 0; c_waddr = 0; c_iss_addr = 0; c_wdata = 0; c_ra = 0;
  endtask

  task automatic test_reset();
    idle_all();
    #1 rst = 1'b1;
    #1;
    checks++;
    if (a_busy !== 32'd0) begin failures++; $display("FAIL reset_busy got=%h exp=%h", a_busy, 32'd0); end
    checks++;
    if (a_rdata !== 64'd0) begin failures++; $display("FAIL reset_rdata got=%h exp=%h", a_rdata, 64'd0); end
    repeat (2) tick();
    rst = 1'b0;
    tick();
    // Populate r1/r2, then mark both busy
    a_we = 1; a_waddr = 5'd1; a_wdata = 32'h1111_0001; tick();
    a_waddr = 5'd2; a_wdata = 32'h2222_0002; tick();
    a_we = 0; a_iss = 1; a_iss_addr = 5'd1; tick();
    a_iss_addr = 5'd2; tick();
    a_iss = 0; a_ra = {5'd2, 5'd1};
    #1;
    checks++;
    if (a_busy !== 32'h0000_0006) begin failures++; $display("FAIL premid_busy got=%h exp=%h", a_busy, 32'h6); end
    checks++;
    if (a_rdata !== {32'h2222_0002, 32'h1111_0001}) begin failures++; $display("FAIL premid_rdata got=%h exp=%h", a_rdata, {32'h2222_0002, 32'h1111_0001}); end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (a_busy !== 32'd0) begin failures++; $display("FAIL midreset_busy got=%h exp=%h", a_busy, 32'd0); end
    checks++;
    if (a_rdata !== 64'd0) begin failures++; $display("FAIL midreset_rdata got=%h exp=%h", a_rdata, 64'd0); end
    checks++;
    if (a_rbusy !== 2'b00) begin failures++; $display("FAIL midreset_rbusy got=%b exp=%b", a_rbusy, 2'b00); end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_bypass();
    a_we = 1; a_waddr = 5'd5; a_wdata = 32'hDEAD_BEEF; a_ra = {5'd0, 5'd5};
    #1;
    checks++;
    if (a_rdata[31:0] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL bypass_same_cycle got=%h exp=%h", a_rdata[31:0], 32'hDEAD_BEEF); end
    tick();
    a_we = 0;
    #1;
    checks++;
    if (a_rdata[31:0] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL bypass_stored got=%h exp=%h", a_rdata[31:0], 32'hDEAD_BEEF); end
    a_ra = {5'd5, 5'd5};
    #1;
    checks++;
    if (a_rdata !== {2{32'hDEAD_BEEF}}) begin failures++; $display("FAIL shared_addr got=%h exp=%h", a_rdata, {2{32'hDEAD_BEEF}}); end
  endtask

  task automatic test_zero_reg();
    a_we = 1; a_waddr = 5'd0; a_wdata = 32'hFFFF_FFFF; a_iss = 1; a_iss_addr = 5'd0; a_ra = 10'd0;
    b_we = 1; b_waddr = 5'd0; b_wdata = 32'hFFFF_FFFF; b_ra = 10'd0;
    #1;
    checks++;
    if (a_rdata[31:0] !== 32'd0) begin failures++; $display("FAIL zero_bypass got=%h exp=%h", a_rdata[31:0], 32'd0); end
    checks++;
    if (u_a.wen !== 32'd0) begin failures++; $display("FAIL zero_wen got=%h exp=%h", u_a.wen, 32'd0); end
    checks++;
    if (b_rdata[31:0] !== 32'hFFFF_FFFF) begin failures++; $display("FAIL nozero_bypass got=%h exp=%h", b_rdata[31:0], 32'hFFFF_FFFF); end
    checks++;
    if (u_b.wen !== 32'd1) begin failures++; $display("FAIL nozero_wen got=%h exp=%h", u_b.wen, 32'd1); end
    tick();
    a_we = 0; a_iss = 0; b_we = 0;
    #1;
    checks++;
    if (a_rdata[31:0] !== 32'd0) begin failures++; $display("FAIL zero_read got=%h exp=%h", a_rdata[31:0], 32'd0); end
    checks++;
    if (a_busy[0] !== 1'b0) begin failures++; $display("FAIL zero_busy got=%b exp=%b", a_busy[0], 1'b0); end
    checks++;
    if (b_rdata[31:0] !== 32'hFFFF_FFFF) begin failures++; $display("FAIL nozero_read got=%h exp=%h", b_rdata[31:0], 32'hFFFF_FFFF); end
  endtask

  task automatic test_hazard();
    a_iss = 1; a_iss_addr = 5'd7; tick();
    a_iss = 0; a_ra = {5'd7, 5'd0};
    #1;
    checks++;
    if (a_rbusy[1] !== 1'b1) begin failures++; $display("FAIL hazard_stall got=%b exp=%b", a_rbusy[1], 1'b1); end
    tick();
    a_we = 1; a_waddr = 5'd7; a_wdata = 32'h0000_1234;
    #1;
    checks++;
    if (a_rbusy[1] !== 1'b0) begin failures++; $display("FAIL hazard_wb_rbusy got=%b exp=%b", a_rbusy[1], 1'b0); end
    checks++;
    if (a_rdata[63:32] !== 32'h0000_1234) begin failures++; $display("FAIL hazard_wb_data got=%h exp=%h", a_rdata[63:32], 32'h1234); end
    tick();
    a_we = 0;
    #1;
    checks++;
    if (a_busy[7] !== 1'b0) begin failures++; $display("FAIL hazard_clear got=%b exp=%b", a_busy[7], 1'b0); end
  endtask

  task automatic test_set_clear();
    a_iss = 1; a_iss_addr = 5'd9; tick();
    a_we = 1; a_waddr = 5'd9; a_wdata = 32'hCAFE_0009; a_iss_addr = 5'd9; tick();
    a_we = 0; a_iss = 0; a_ra = {5'd0, 5'd9};
    #1;
    checks++;
    if (a_busy[9] !== 1'b1) begin failures++; $display("FAIL setclr_busy got=%b exp=%b", a_busy[9], 1'b1); end
    checks++;
    if (a_rdata[31:0] !== 32'hCAFE_0009) begin failures++; $display("FAIL setclr_data got=%h exp=%h", a_rdata[31:0], 32'hCAFE_0009); end
    // Second issue on a busy register: one write-back clears it
    a_iss = 1; tick();
    a_iss = 0; a_we = 1; a_wdata = 32'h0000_0099; tick();
    a_we = 0;
    #1;
    checks++;
    if (a_busy[9] !== 1'b0) begin failures++; $display("FAIL waw_clear got=%b exp=%b", a_busy[9], 1'b0); end
  endtask

  task automatic test_sweep();
    c_we = 1; c_waddr = 3'd3; c_wdata = 16'h00A5; tick();
    c_we = 0; c_ra = {3'd7, 3'd0, 3'd3, 3'd3};
    #1;
    checks++;
    if (c_rdata !== {16'h0000, 16'h0000, 16'h00A5, 16'h00A5}) begin failures++; $display("FAIL sweep_rdata got=%h exp=%h", c_rdata, {16'h0, 16'h0, 16'h00A5, 16'h00A5}); end
    checks++;
    if (c_rbusy !== 4'b0000) begin failures++; $display("FAIL sweep_rbusy got=%b exp=%b", c_rbusy, 4'b0); end
    c_iss = 1; c_iss_addr = 3'd7; tick();
    c_iss = 0;
    #1;
    checks++;
    if (c_rbusy !== 4'b1000) begin failures++; $display("FAIL sweep_busy7 got=%b exp=%b", c_rbusy, 4'b1000); end
  endtask

  task automatic test_random();
    logic [4:0] r0, r1;
    for (int n = 0; n < 400; n++) begin
      a_we       = ($urandom_range(0, 1) == 1);
      a_waddr    = 5'($urandom_range(0, 31));
      a_wdata    = $urandom;
      a_iss      = ($urandom_range(0, 2) == 0);
      a_iss_addr = ($urandom_range(0, 3) == 0) ? a_waddr : 5'($urandom_range(0, 31));
      r0 = ($urandom_range(0, 3) == 0) ? a_waddr : 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 3) == 0) ? a_iss_addr : 5'($urandom_range(0, 31));
      a_ra = {r1, r0};
      #1;
      checks++;
      if (a_rdata !== {exp_rd(r1), exp_rd(r0)}) begin failures++; $display("FAIL rand_rdata n=%0d got=%h exp=%h", n, a_rdata, {exp_rd(r1), exp_rd(r0)}); end
      checks++;
      if (a_rbusy !== {exp_busy(r1), exp_busy(r0)}) begin failures++; $display("FAIL rand_rbusy n=%0d got=%b exp=%b", n, a_rbusy, {exp_busy(r1), exp_busy(r0)}); end
      checks++;
      if (a_busy !== m_busy) begin failures++; $display("FAIL rand_busyvec n=%0d got=%h exp=%h", n, a_busy, m_busy); end
      tick();
    end
    idle_all();
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_zero_reg();
    test_hazard();
    test_set_clear();
    test_sweep();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
